// File: rtl/ahb_grant_ctrl_if.sv
// Bus-side signal bundle of the AHB grant controller.
// Groups the master requests, transfer qualifiers, the find-first priority
// counter handshake and the registered grant outputs.
//   master : request/transfer side and priority counter result (drives requests)
//   slave  : grant controller side (drives pe_req and the grant outputs)
interface ahb_grant_ctrl_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned LOGN = $clog2(N);

    logic [N-1:0]    HBUSREQ;
    logic [N-1:0]    HLOCK;
    logic [1:0]      HTRANS;
    logic [2:0]      HBURST;
    logic            HREADY;
    logic [N-1:0]    pe_req;
    logic [LOGN-1:0] pe_idx;
    logic            pe_valid;
    logic [N-1:0]    HGRANT;
    logic [LOGN-1:0] HMASTER;
    logic            HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, pe_idx, pe_valid,
        input  pe_req, HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, pe_idx, pe_valid,
        output pe_req, HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_grant_ctrl.sv
// Registered grant controller of the AHB arbiter.
// Presents the (optionally rotated) request vector to an external find-first
// priority counter, uses its idx/valid result in the same cycle, and holds the
// grant across fixed-length bursts and locked sequences.
//   HCLK   : clock, rising edge
//   HRESET : asynchronous reset, active-high
//   bus    : requests, transfer qualifiers, priority counter handshake,
//            registered HGRANT / HMASTER / HMASTLOCK
module ahb_grant_ctrl #(
    parameter int unsigned N              = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter bit          RR             = 1'b0
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_grant_ctrl_if.slave bus
);
    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned REMW = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_OWN      = 2'd1,
        S_HANDOVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [LOGN-1:0] master_q, master_d;
    logic            mastlock_q, mastlock_d;
    logic            lock_pend_q, lock_pend_d;
    logic [REMW-1:0] rem_q, rem_d;
    logic [LOGN-1:0] last_q, last_d;

    logic [LOGN:0]   start_c;
    logic [LOGN:0]   wsum_c;
    logic [LOGN-1:0] winner_c;
    logic [N-1:0]    req_rot_c;
    logic [N-1:0]    new_grant_c;
    logic            new_lock_c;
    logic [LOGN-1:0] grant_idx_c;
    logic [REMW-1:0] rem_upd_c;
    logic [REMW-1:0] burst_len_c;
    logic            owner_locked_c;
    logic            arb_c;

    // Rotation start: (last+1) mod N for round-robin, 0 for fixed priority.
    always_comb begin
        start_c = '0;
        if (RR) begin
            start_c = (LOGN+1)'(last_q) + (LOGN+1)'(1);
            if (start_c >= (LOGN+1)'(N)) start_c = start_c - (LOGN+1)'(N);
        end
    end

    // Request vector rotated right by start_c.
    always_comb begin
        logic [LOGN:0] sum;
        req_rot_c = '0;
        for (int i = 0; i < N; i++) begin
            sum = (LOGN+1)'(i) + start_c;
            if (sum >= (LOGN+1)'(N)) sum = sum - (LOGN+1)'(N);
            req_rot_c[i] = bus.HBUSREQ[sum[LOGN-1:0]];
        end
    end

    assign bus.pe_req = req_rot_c;

    // Undo the rotation on the priority counter result.
    always_comb begin
        wsum_c = {1'b0, bus.pe_idx} + start_c;
        if (wsum_c >= (LOGN+1)'(N)) wsum_c = wsum_c - (LOGN+1)'(N);
        winner_c = wsum_c[LOGN-1:0];
    end

    assign new_grant_c = bus.pe_valid ? (N'(1) << winner_c) : (N'(1) << DEFAULT_MASTER);
    assign new_lock_c  = bus.pe_valid & bus.HLOCK[winner_c];

    // Index of the current one-hot grant.
    always_comb begin
        grant_idx_c = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) grant_idx_c = LOGN'(i);
        end
    end

    // Remaining SEQ beats implied by the burst type of a NONSEQ.
    always_comb begin
        burst_len_c = '0;
        case (bus.HBURST)
            3'b000, 3'b001: burst_len_c = REMW'(0);
            3'b010, 3'b011: burst_len_c = REMW'(3);
            3'b100, 3'b101: burst_len_c = REMW'(7);
            3'b110, 3'b111: burst_len_c = REMW'(15);
            default:        burst_len_c = '0;
        endcase
    end

    // Beat accounting for the current address-phase owner.
    always_comb begin
        rem_upd_c = rem_q;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                2'b10:   rem_upd_c = burst_len_c;
                2'b11:   rem_upd_c = (rem_q != '0) ? rem_q - REMW'(1) : '0;
                2'b00:   rem_upd_c = '0;
                default: rem_upd_c = rem_q;
            endcase
        end
    end

    assign owner_locked_c = bus.HLOCK[master_q] & bus.HBUSREQ[master_q];
    assign arb_c          = bus.HREADY & (rem_upd_c == '0) & ~owner_locked_c;

    // State register and output registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            grant_q     <= N'(1) << DEFAULT_MASTER;
            master_q    <= LOGN'(DEFAULT_MASTER);
            mastlock_q  <= 1'b0;
            lock_pend_q <= 1'b0;
            rem_q       <= '0;
            last_q      <= LOGN'(DEFAULT_MASTER);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            master_q    <= master_d;
            mastlock_q  <= mastlock_d;
            lock_pend_q <= lock_pend_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        master_d    = master_q;
        mastlock_d  = mastlock_q;
        lock_pend_d = lock_pend_q;
        rem_d       = rem_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE, S_OWN: begin
                rem_d = rem_upd_c;
                if (arb_c) begin
                    grant_d     = new_grant_c;
                    lock_pend_d = new_lock_c;
                    if (new_grant_c != grant_q) begin
                        state_d = S_HANDOVER;
                    end else begin
                        // Same owner re-granted: HMASTER already matches, lock follows now.
                        mastlock_d = new_lock_c;
                        state_d    = bus.pe_valid ? S_OWN : S_IDLE;
                    end
                end
            end
            S_HANDOVER: begin
                if (bus.HREADY) begin
                    master_d   = grant_idx_c;
                    mastlock_d = lock_pend_q;
                    last_d     = grant_idx_c;
                    rem_d      = '0;
                    state_d    = S_OWN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_grant_ctrl.sv
// Directed bench for ahb_grant_ctrl: a fixed-priority and a round-robin
// instance, each with a find-first priority counter model on pe_req.
module tb_ahb_grant_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ahb_grant_ctrl_if #(.N(4)) bus0 ();
    ahb_grant_ctrl_if #(.N(4)) bus1 ();

    ahb_grant_ctrl #(.N(4), .DEFAULT_MASTER(0), .RR(1'b0)) dut0 (
        .HCLK(clk), .HRESET(rst), .bus(bus0)
    );
    ahb_grant_ctrl #(.N(4), .DEFAULT_MASTER(0), .RR(1'b1)) dut1 (
        .HCLK(clk), .HRESET(rst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Find-first priority counter model (lowest set bit).
    always_comb begin
        bus0.pe_idx   = 2'd0;
        bus0.pe_valid = |bus0.pe_req;
        for (int i = 3; i >= 0; i--) if (bus0.pe_req[i]) bus0.pe_idx = 2'(i);
    end
    always_comb begin
        bus1.pe_idx   = 2'd0;
        bus1.pe_valid = |bus1.pe_req;
        for (int i = 3; i >= 0; i--) if (bus1.pe_req[i]) bus1.pe_idx = 2'(i);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.HBUSREQ = '0; bus0.HLOCK = '0; bus0.HTRANS = 2'b00; bus0.HBURST = 3'b000; bus0.HREADY = 1'b1;
        bus1.HBUSREQ = '0; bus1.HLOCK = '0; bus1.HTRANS = 2'b00; bus1.HBURST = 3'b000; bus1.HREADY = 1'b1;
        tick(); tick();
        checks++;
        if (bus0.HGRANT !== 4'b0001 || bus0.HMASTER !== 2'd0 || bus0.HMASTLOCK !== 1'b0) begin
            failures++;
            $display("FAIL reset_in got grant=%b master=%0d lock=%b exp 0001/0/0", bus0.HGRANT, bus0.HMASTER, bus0.HMASTLOCK);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus0.HGRANT !== 4'b0001 || bus0.HMASTER !== 2'd0 || bus0.HMASTLOCK !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got grant=%b master=%0d lock=%b exp 0001/0/0", c, bus0.HGRANT, bus0.HMASTER, bus0.HMASTLOCK);
            end
        end
        checks++;
        if (bus1.HGRANT !== 4'b0001 || bus1.HMASTER !== 2'd0) begin
            failures++;
            $display("FAIL reset_rr got grant=%b master=%0d exp 0001/0", bus1.HGRANT, bus1.HMASTER);
        end
    endtask

    task automatic test_fixed_priority();
        bus0.HBUSREQ = 4'b1010;
        tick();
        checks++;
        if (bus0.HGRANT !== 4'b0010) begin
            failures++; $display("FAIL fp_grant got=%b exp=0010", bus0.HGRANT);
        end
        checks++;
        if (bus0.HMASTER !== 2'd0) begin
            failures++; $display("FAIL fp_master_early got=%0d exp=0", bus0.HMASTER);
        end
        tick();
        checks++;
        if (bus0.HMASTER !== 2'd1) begin
            failures++; $display("FAIL fp_master got=%0d exp=1", bus0.HMASTER);
        end
    endtask

    task automatic test_burst_hold();
        logic [1:0] tr [5];
        logic       rdy [5];
        tr  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bus0.HBURST = 3'b011;
        for (int b = 0; b < 5; b++) begin
            bus0.HTRANS  = tr[b];
            bus0.HREADY  = rdy[b];
            bus0.HBUSREQ = (b == 0) ? 4'b1010 : 4'b1000;
            tick();
            checks++;
            if (b < 4 && bus0.HGRANT !== 4'b0010) begin
                failures++; $display("FAIL burst_hold beat=%0d got=%b exp=0010", b, bus0.HGRANT);
            end else if (b == 4 && bus0.HGRANT !== 4'b1000) begin
                failures++; $display("FAIL burst_release got=%b exp=1000", bus0.HGRANT);
            end
        end
        bus0.HTRANS = 2'b00; bus0.HBURST = 3'b000; bus0.HREADY = 1'b1;
        tick();
        checks++;
        if (bus0.HMASTER !== 2'd3) begin
            failures++; $display("FAIL burst_master got=%0d exp=3", bus0.HMASTER);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        int         n;
        bus1.HBUSREQ = 4'b1111; bus1.HTRANS = 2'b10; bus1.HBURST = 3'b000; bus1.HREADY = 1'b1;
        prev = bus1.HMASTER;
        checks++;
        if (prev !== 2'd0) begin
            failures++; $display("FAIL rr_start got=%0d exp=0", prev);
        end
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (bus1.HMASTER === prev && n < 8) begin
                tick();
                n++;
            end
            checks++;
            if (bus1.HMASTER !== 2'(k % 4)) begin
                failures++; $display("FAIL rr_seq step=%0d got=%0d exp=%0d waited=%0d", k, bus1.HMASTER, k % 4, n);
            end
            checks++;
            if (bus1.HGRANT !== 4'(1 << (k % 4))) begin
                failures++; $display("FAIL rr_grant step=%0d got=%b exp=%b", k, bus1.HGRANT, 4'(1 << (k % 4)));
            end
            prev = bus1.HMASTER;
        end
        bus1.HBUSREQ = '0; bus1.HTRANS = 2'b00;
    endtask

    task automatic test_lock();
        bus0.HBUSREQ = 4'b0100; bus0.HLOCK = 4'b0100;
        tick(); tick();
        checks++;
        if (bus0.HGRANT !== 4'b0100 || bus0.HMASTER !== 2'd2 || bus0.HMASTLOCK !== 1'b1) begin
            failures++;
            $display("FAIL lock_take got grant=%b master=%0d lock=%b exp 0100/2/1", bus0.HGRANT, bus0.HMASTER, bus0.HMASTLOCK);
        end
        bus0.HBUSREQ = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (bus0.HGRANT !== 4'b0100 || bus0.HMASTLOCK !== 1'b1) begin
                failures++; $display("FAIL lock_hold cyc=%0d got grant=%b lock=%b exp 0100/1", c, bus0.HGRANT, bus0.HMASTLOCK);
            end
        end
        bus0.HLOCK = 4'b0000;
        tick();
        checks++;
        if (bus0.HGRANT !== 4'b0001) begin
            failures++; $display("FAIL lock_release got=%b exp=0001", bus0.HGRANT);
        end
        tick();
        checks++;
        if (bus0.HMASTER !== 2'd0 || bus0.HMASTLOCK !== 1'b0) begin
            failures++; $display("FAIL lock_handover got master=%0d lock=%b exp 0/0", bus0.HMASTER, bus0.HMASTLOCK);
        end
    endtask

    task automatic test_reset_mid_burst();
        bus0.HBUSREQ = 4'b0010;
        tick(); tick();
        checks++;
        if (bus0.HMASTER !== 2'd1) begin
            failures++; $display("FAIL rst_setup got=%0d exp=1", bus0.HMASTER);
        end
        bus0.HBURST = 3'b101;
        bus0.HTRANS = 2'b10;
        tick();
        bus0.HBUSREQ = 4'b0001;
        bus0.HTRANS  = 2'b11;
        tick(); tick();
        checks++;
        if (bus0.HGRANT !== 4'b0010) begin
            failures++; $display("FAIL rst_burst_hold got=%b exp=0010", bus0.HGRANT);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus0.HGRANT !== 4'b0001 || bus0.HMASTER !== 2'd0 || bus0.HMASTLOCK !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got grant=%b master=%0d lock=%b exp 0001/0/0", bus0.HGRANT, bus0.HMASTER, bus0.HMASTLOCK);
        end
        tick();
        checks++;
        if (bus0.HGRANT !== 4'b0001 || bus0.HMASTER !== 2'd0) begin
            failures++; $display("FAIL rst_held got grant=%b master=%0d exp 0001/0", bus0.HGRANT, bus0.HMASTER);
        end
        rst = 1'b0;
        bus0.HTRANS = 2'b00; bus0.HBURST = 3'b000; bus0.HBUSREQ = 4'b0010;
        tick();
        checks++;
        if (bus0.HGRANT !== 4'b0010 || bus0.HMASTER !== 2'd0) begin
            failures++; $display("FAIL rst_rearb got grant=%b master=%0d exp 0010/0", bus0.HGRANT, bus0.HMASTER);
        end
        tick();
        checks++;
        if (bus0.HMASTER !== 2'd1) begin
            failures++; $display("FAIL rst_rearb_master got=%0d exp=1", bus0.HMASTER);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fixed_priority();
        test_burst_hold();
        test_round_robin();
        test_lock();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
